// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared definitions for the memory-port arbiter and its bus watchdog:
//   - BUS_W      : width of the memory bus address/data paths
//   - SEL_WORD   : byte-lane select used for full-word accesses (fetches)
//   - ST_*       : arbiter FSM state encoding
//   - cnt_width  : width of the watchdog counter for a given timeout
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

    localparam int unsigned BUS_W = 32;

    localparam logic [3:0] SEL_WORD = 4'b1111;

    typedef logic [BUS_W-1:0] word_t;

    // Arbiter FSM states.
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_IF_BUSY = 2'd1;
    localparam logic [1:0] ST_DM_BUSY = 2'd2;
    localparam logic [1:0] ST_RESP    = 2'd3;

    // Counter must hold 0..timeout; a disabled timeout (0) still needs one
    // bit so the counter declaration stays legal.
    function automatic int unsigned cnt_width(input int unsigned timeout);
        return (timeout == 0) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/mem_bus_watchdog.sv
// -----------------------------------------------------------------------------
// mem_bus_watchdog
// Counts cycles spent waiting on the memory bus and flags when the wait has
// lasted TIMEOUT_CYCLES cycles. TIMEOUT_CYCLES = 0 disables the flag.
// Ports:
//   i_clk      : clock
//   i_rst_n    : asynchronous active-low reset
//   i_clear    : restart the count (asserted on the cycle a bus wait begins)
//   i_enable   : high on every cycle spent waiting for the bus
//   o_expired  : high during the TIMEOUT_CYCLES-th consecutive wait cycle
// -----------------------------------------------------------------------------
module mem_bus_watchdog
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int unsigned CW     = cnt_width(TIMEOUT_CYCLES);
    localparam int unsigned LAST_I = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam logic [CW-1:0] LAST = CW'(LAST_I);
    localparam logic [CW-1:0] MAX  = CW'(TIMEOUT_CYCLES);

    // r_count holds the number of wait cycles already completed, so the
    // current cycle is wait number r_count+1.
    logic [CW-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != MAX)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = (TIMEOUT_CYCLES != 0) && i_enable && (r_count >= LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one memory bus between an instruction-fetch port and a data port.
// Data requests win over fetches. Every bus output is registered; a single
// response cycle (RESP) pulses the ack of the served port with rdata/err.
// Misaligned data requests are answered with an error without using the bus,
// and a bus wait longer than TIMEOUT_CYCLES is aborted with an error.
// Ports:
//   i_clk, i_rst_n                 : clock, asynchronous active-low reset
//   i_if_req, i_if_addr            : fetch request (held until ack), address
//   o_if_ack, o_if_err, o_if_rdata : fetch completion pulse, error, word
//   i_dm_req, i_dm_we, i_dm_bad_addr, i_dm_addr, i_dm_wdata, i_dm_sel
//                                  : data request, write, misaligned flag,
//                                    address, write data, byte lanes
//   o_dm_ack, o_dm_err, o_dm_rdata : data completion pulse, error, word
//   o_bus_req, o_bus_we, o_bus_addr, o_bus_wdata, o_bus_sel
//                                  : registered memory bus request
//   i_bus_ack, i_bus_rdata         : memory bus completion, read data
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_if_req,
    input  logic [31:0] i_if_addr,
    output logic        o_if_ack,
    output logic        o_if_err,
    output logic [31:0] o_if_rdata,
    input  logic        i_dm_req,
    input  logic        i_dm_we,
    input  logic        i_dm_bad_addr,
    input  logic [31:0] i_dm_addr,
    input  logic [31:0] i_dm_wdata,
    input  logic [3:0]  i_dm_sel,
    output logic        o_dm_ack,
    output logic        o_dm_err,
    output logic [31:0] o_dm_rdata,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [31:0] o_bus_wdata,
    output logic [3:0]  o_bus_sel,
    input  logic        i_bus_ack,
    input  logic [31:0] i_bus_rdata
);

    logic [1:0] r_state;
    logic       r_if_ack, r_if_err, r_dm_ack, r_dm_err;
    word_t      r_if_rdata, r_dm_rdata;
    logic       r_bus_req, r_bus_we;
    word_t      r_bus_addr, r_bus_wdata;
    logic [3:0] r_bus_sel;

    logic w_busy, w_grant_dm, w_grant_if, w_clear, w_expired;

    assign w_busy     = (r_state == ST_IF_BUSY) || (r_state == ST_DM_BUSY);
    assign w_grant_dm = (r_state == ST_IDLE) && i_dm_req;
    assign w_grant_if = (r_state == ST_IDLE) && !i_dm_req && i_if_req;
    // The counter restarts only on grants that actually go onto the bus.
    assign w_clear    = (w_grant_dm && !i_dm_bad_addr) || w_grant_if;

    mem_bus_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clear   (w_clear),
        .i_enable  (w_busy),
        .o_expired (w_expired)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_if_ack    <= 1'b0;
            r_if_err    <= 1'b0;
            r_if_rdata  <= '0;
            r_dm_ack    <= 1'b0;
            r_dm_err    <= 1'b0;
            r_dm_rdata  <= '0;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_bus_sel   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_dm) begin
                        if (i_dm_bad_addr) begin
                            // Misaligned: answer straight away, bus untouched.
                            r_dm_ack   <= 1'b1;
                            r_dm_err   <= 1'b1;
                            r_dm_rdata <= '0;
                            r_state    <= ST_RESP;
                        end else begin
                            r_bus_req   <= 1'b1;
                            r_bus_we    <= i_dm_we;
                            r_bus_addr  <= i_dm_addr;
                            r_bus_wdata <= i_dm_wdata;
                            r_bus_sel   <= i_dm_sel;
                            r_state     <= ST_DM_BUSY;
                        end
                    end else if (w_grant_if) begin
                        r_bus_req   <= 1'b1;
                        r_bus_we    <= 1'b0;
                        r_bus_addr  <= i_if_addr;
                        r_bus_wdata <= '0;
                        r_bus_sel   <= SEL_WORD;
                        r_state     <= ST_IF_BUSY;
                    end
                end
                ST_IF_BUSY, ST_DM_BUSY: begin
                    // A bus ack in the timeout cycle still completes normally.
                    if (i_bus_ack || w_expired) begin
                        r_bus_req <= 1'b0;
                        r_state   <= ST_RESP;
                        if (r_state == ST_DM_BUSY) begin
                            r_dm_ack   <= 1'b1;
                            r_dm_err   <= !i_bus_ack;
                            r_dm_rdata <= i_bus_ack ? i_bus_rdata : '0;
                        end else begin
                            r_if_ack   <= 1'b1;
                            r_if_err   <= !i_bus_ack;
                            r_if_rdata <= i_bus_ack ? i_bus_rdata : '0;
                        end
                    end
                end
                ST_RESP: begin
                    // Response data is only visible during the ack cycle.
                    r_if_ack   <= 1'b0;
                    r_if_err   <= 1'b0;
                    r_if_rdata <= '0;
                    r_dm_ack   <= 1'b0;
                    r_dm_err   <= 1'b0;
                    r_dm_rdata <= '0;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_if_ack    = r_if_ack;
    assign o_if_err    = r_if_err;
    assign o_if_rdata  = r_if_rdata;
    assign o_dm_ack    = r_dm_ack;
    assign o_dm_err    = r_dm_err;
    assign o_dm_rdata  = r_dm_rdata;
    assign o_bus_req   = r_bus_req;
    assign o_bus_we    = r_bus_we;
    assign o_bus_addr  = r_bus_addr;
    assign o_bus_wdata = r_bus_wdata;
    assign o_bus_sel   = r_bus_sel;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum number of bus-wait cycles before abort; 0 disables the timeout.
REQ-002 SHALL have port i_clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port i_rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port i_if_req  input  1  instruction-fetch request, held until o_if_ack.
REQ-005 SHALL have port i_if_addr  input  32  fetch word address.
REQ-006 SHALL have ports o_if_ack/o_if_err  output  1 each  fetch completion pulse / error flag.
REQ-007 SHALL have port o_if_rdata  output  32  fetched word.
REQ-008 SHALL have ports i_dm_req/i_dm_we/i_dm_bad_addr  input  1 each  data request / write / misaligned flag from the address processor.
REQ-009 SHALL have ports i_dm_addr/i_dm_wdata  input  32 each, and i_dm_sel  input  4  byte-lane select.
REQ-010 SHALL have ports o_dm_ack/o_dm_err  output  1 each, and o_dm_rdata  output  32.
REQ-011 SHALL have ports o_bus_req/o_bus_we  output  1 each; o_bus_addr/o_bus_wdata  output  32 each; o_bus_sel  output  4.
REQ-012 SHALL have ports i_bus_ack  input  1 and i_bus_rdata  input  32.

Function
REQ-013 SHALL implement states IDLE, IF_BUSY, DM_BUSY, RESP.
REQ-014 SHALL, in IDLE, grant data over fetch when both requests are high; no grant when neither is high.
REQ-015 SHALL, on a data grant with i_dm_bad_addr=1, skip the bus, enter RESP with o_dm_err=1 and o_dm_rdata=0.
REQ-016 SHALL register all bus outputs: a request sampled in IDLE at cycle N drives o_bus_req=1 from cycle N+1.
REQ-017 SHALL hold o_bus_addr/we/wdata/sel stable while o_bus_req=1; a fetch drives we=0 and sel=4'b1111.
REQ-018 SHALL, on i_bus_ack=1 in a BUSY state at cycle M, drop o_bus_req, capture i_bus_rdata, and enter RESP, so that o_*_ack=1 with rdata valid at cycle M+1.
REQ-019 SHALL pulse exactly one of o_if_ack/o_dm_ack for one cycle in RESP, then return to IDLE without granting in the RESP cycle.
REQ-020 SHALL hold o_*_rdata and o_*_err only during the ack cycle; they SHALL be 0 otherwise.
REQ-021 SHALL count BUSY cycles; when the count reaches TIMEOUT_CYCLES without ack, it SHALL drop o_bus_req, enter RESP with err=1 and rdata=0.
REQ-022 SHALL give ack priority when ack and timeout occur in the same cycle (completion, err=0).
REQ-023 SHALL ignore i_bus_ack in IDLE and RESP.
REQ-024 SHALL size the counter as clog2(TIMEOUT_CYCLES+1) bits, saturating, and clear it on every BUSY entry.
REQ-025 SHALL give minimum transaction latency from request to ack of 3 cycles (bus ack in first BUSY cycle).

Reset
REQ-026 SHALL, on i_rst_n=0, force state IDLE, counter 0, and all outputs 0 immediately, regardless of clock, including mid-transaction.
REQ-027 SHALL sample requests only on the first rising edge after i_rst_n rises; aborted transactions SHALL NOT be acked.

Structure
REQ-028 SHALL place the state encoding, the SEL_WORD (4'b1111) constant, and the bus width constant in the shared package.
REQ-029 SHALL place the timeout counter in one sub-module, mem_bus_watchdog (inputs clear/enable, output expired).

Verification
REQ-030 SHALL cover: if_req=1, addr=0x00400000, ack after 2 cycles with rdata=0x8C010004 -> o_if_ack=1 and o_if_rdata=0x8C010004 one cycle after ack, err=0.
REQ-031 SHALL cover: if_req and dm_req together, dm we=1, addr=0x10010008, sel=0011, wdata=0x00001234 -> the data bus transaction goes first with exact fields, then the fetch.
REQ-032 SHALL cover: dm_req with bad_addr=1 -> o_bus_req stays 0, o_dm_ack=1, o_dm_err=1 two cycles after the request.
REQ-033 SHALL cover: TIMEOUT_CYCLES=4, no ack -> o_bus_req high for exactly 4 cycles, then o_dm_err=1; ack coinciding with the 4th cycle -> err=0.
REQ-034 SHALL cover: i_rst_n low mid-DM_BUSY -> o_bus_req=0 asynchronously, no ack; after release, the held request restarts cleanly.
REQ-035 SHALL cover: a spurious i_bus_ack in IDLE -> no output change.
